mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, memory access cycles per transaction (legal 1..7).
REQ-002 SHALL have parameter STARVE_MAX, default 4, consecutive data grants before a waiting fetch is forced.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port if_req  in  1  fetch request; held high until if_ack.
REQ-006 SHALL have port if_addr  in  32  fetch byte address.
REQ-007 SHALL have port if_rdata  out  32  fetched instruction; valid while if_ack=1.
REQ-008 SHALL have port if_ack  out  1  one-cycle fetch completion pulse.
REQ-009 SHALL have port d_req  in  1  data request; held high until d_ack.
REQ-010 SHALL have port d_we  in  1  1=store, 0=load.
REQ-011 SHALL have port d_addr  in  32  data byte address.
REQ-012 SHALL have port d_wdata  in  32  store data.
REQ-013 SHALL have port d_rdata  out  32  load data; valid while d_ack=1 after a load.
REQ-014 SHALL have port d_ack  out  1  one-cycle data completion pulse.
REQ-015 SHALL have port mem_en  out  1  single-port memory enable.
REQ-016 SHALL have port mem_we  out  1  memory write enable.
REQ-017 SHALL have port mem_addr  out  10  word address (1024-word memory).
REQ-018 SHALL have port mem_wdata  out  32  memory write data.
REQ-019 SHALL have port mem_rdata  in  32  memory read data, sampled on last access cycle.
REQ-020 SHALL have port stall  out  1  pipeline freeze = (if_req&~if_ack)|(d_req&~d_ack).

Function
REQ-021 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-022 SHALL, in IDLE with any request, accept one request that cycle (T0), register addr>>2 (bits [11:2]), we, wdata, and owner, and go to ACCESS.
REQ-023 SHALL grant data over fetch, except fetch wins when both request and starve counter == STARVE_MAX.
REQ-024 SHALL increment starve counter on a data grant made while if_req=1, clear it on any fetch grant, saturate at STARVE_MAX.
REQ-025 SHALL in ACCESS assert mem_en for exactly MEM_LAT cycles (T0+1..T0+MEM_LAT), holding mem_addr/mem_we/mem_wdata stable; mem_we=0 for fetches.
REQ-026 SHALL capture mem_rdata on cycle T0+MEM_LAT into the owner's rdata register, only for fetches and loads.
REQ-027 SHALL go to DONE at T0+MEM_LAT+1, pulse only the owner's ack for that one cycle, then return to IDLE.
REQ-028 SHALL ignore both req inputs while in ACCESS or DONE; total transaction occupancy = MEM_LAT+2 cycles.
REQ-029 SHALL hold if_rdata/d_rdata between transactions; stores leave d_rdata unchanged.
REQ-030 SHALL drive mem_en=0, mem_we=0 outside ACCESS; mem_addr/mem_wdata hold last value.
REQ-031 SHALL ignore address bits [1:0] and [31:12] (no misalignment or range fault).
REQ-032 SHALL treat a requester deasserting req mid-transaction as don't-care; the transaction completes and acks.

Reset
REQ-033 SHALL, with reset=1 at a clock edge, force IDLE, clear starve counter, if_ack/d_ack/mem_en/mem_we to 0, and if_rdata/d_rdata/mem_addr/mem_wdata to 0, including mid-ACCESS (in-flight access abandoned, no ack).
REQ-034 SHALL accept a new request in the first cycle after reset deasserts.

Verification
REQ-035 SHALL test lone fetch: MEM_LAT=2, if_req@T0, addr 0x10, mem_rdata=0x00000013 at T2 -> mem_addr=4, mem_en T1-T2, if_ack+if_rdata=0x13 at T3, stall high T0-T2.
REQ-036 SHALL test store then load: store 0xDEADBEEF to 0x40 -> mem_we=1 T1-T2, d_ack T3; load 0x40 accepted T4 -> d_rdata=0xDEADBEEF with d_ack T7.
REQ-037 SHALL test simultaneous if_req and d_req at T0 -> data granted first, d_ack T3, fetch accepted T4, if_ack T7.
REQ-038 SHALL test starvation: if_req held with d_req continuous -> 4 data acks, then fetch ack, counter cleared, data resumes.
REQ-039 SHALL test reset at T1 of a load -> mem_en=0 at T2, no d_ack, state IDLE, re-issued load completes normally.
REQ-040 SHALL test MEM_LAT=1 and MEM_LAT=7 -> ack at T0+2 and T0+8 respectively.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data request ports, memory port and stall for the arbiter
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ack;
   logic        mem_en;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        stall;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, stall
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, stall
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch and data requesters
module mem_port_arbiter #(
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input logic              clk,
   input logic              reset,
   mem_port_arbiter_if.slave bus
);
   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [2:0]    LAST_CYC   = 3'(MEM_LAT - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t        state, state_nx;
   logic [2:0]    cyc;
   logic [SW-1:0] starve;
   logic          owner_fetch;
   logic          we_r;
   logic [9:0]    addr_r;
   logic [31:0]   wdata_r;
   logic [31:0]   if_rdata_r;
   logic [31:0]   d_rdata_r;
   logic          grant_fetch;
   logic          accept;
   logic          last_cyc;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.if_addr[31:12], bus.if_addr[1:0],
                               bus.d_addr[31:12], bus.d_addr[1:0]};

   always_comb begin
      state_nx    = state;
      accept      = 1'b0;
      last_cyc    = (cyc == LAST_CYC);
      // data has priority unless the fetch side has been passed over STARVE_MAX times
      grant_fetch = bus.if_req && (!bus.d_req || starve == STARVE_LIM);
      case (state)
         IDLE: begin
            if (bus.if_req || bus.d_req) begin
               accept   = 1'b1;
               state_nx = ACCESS;
            end
         end
         ACCESS:  if (last_cyc) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cyc         <= 3'd0;
         starve      <= '0;
         owner_fetch <= 1'b0;
         we_r        <= 1'b0;
         addr_r      <= 10'd0;
         wdata_r     <= 32'd0;
         if_rdata_r  <= 32'd0;
         d_rdata_r   <= 32'd0;
      end else begin
         state <= state_nx;
         if (accept) begin
            cyc         <= 3'd0;
            owner_fetch <= grant_fetch;
            addr_r      <= grant_fetch ? bus.if_addr[11:2] : bus.d_addr[11:2];
            we_r        <= !grant_fetch && bus.d_we;
            if (!grant_fetch) wdata_r <= bus.d_wdata;
            if (grant_fetch)
               starve <= '0;
            else if (bus.if_req && starve != STARVE_LIM)
               starve <= starve + 1'b1;
         end
         if (state == ACCESS) begin
            cyc <= cyc + 3'd1;
            if (last_cyc && !we_r) begin
               if (owner_fetch) if_rdata_r <= bus.mem_rdata;
               else             d_rdata_r  <= bus.mem_rdata;
            end
         end
      end
   end

   assign bus.mem_en    = (state == ACCESS);
   assign bus.mem_we    = (state == ACCESS) && we_r;
   assign bus.mem_addr  = addr_r;
   assign bus.mem_wdata = wdata_r;
   assign bus.if_ack    = (state == DONE) && owner_fetch;
   assign bus.d_ack     = (state == DONE) && !owner_fetch;
   assign bus.if_rdata  = if_rdata_r;
   assign bus.d_rdata   = d_rdata_r;
   assign bus.stall     = (bus.if_req && !bus.if_ack) || (bus.d_req && !bus.d_ack);
endmodule
